// File: rtl/ir_cmd_pkg.sv
// Shared types and default constants for the IR drive link (transmitter and receiver).
package ir_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_STOP  = 2'd0,
    CMD_UP    = 2'd1,
    CMD_RIGHT = 2'd2,
    CMD_LEFT  = 2'd3
  } cmd_code_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_e;

  // Default timing: one frame is 25,000,000 cycles, i.e. one receiver window at 50 MHz.
  localparam int unsigned PERIOD_CYCLES_DEF     = 1000;
  localparam int unsigned PERIODS_PER_FRAME_DEF = 25000;
  localparam int unsigned FRAMES_PER_CMD_DEF    = 2;
  localparam int unsigned LOW_UP_DEF            = 232;
  localparam int unsigned LOW_RIGHT_DEF         = 264;
  localparam int unsigned LOW_LEFT_DEF          = 276;

  // Receiver classification thresholds on low cycles per window.
  localparam int unsigned RX_BAND_UP_MIN    = 5_000_000;
  localparam int unsigned RX_BAND_RIGHT_MIN = 6_500_000;
  localparam int unsigned RX_BAND_LEFT_MIN  = 6_700_000;

  // Counter width for a modulus n; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ir_cmd_tx_pwm.sv
// Sub-period phase counter and low-time compare. ir_out is registered from the
// next phase value so the line lines up with the frame sequencing in ir_cmd_tx.
module ir_pwm_period
  import ir_cmd_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = PERIOD_CYCLES_DEF,
  parameter int unsigned PW            = cnt_w(PERIOD_CYCLES)
) (
  input  logic          clkin,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  input  logic          en_nxt,
  input  logic [PW-1:0] low_len_nxt,
  output logic          wrap,
  output logic          ir_out
);

  logic [PW-1:0] phase_cnt;
  logic [PW-1:0] phase_nxt;

  assign wrap = (phase_cnt == PW'(PERIOD_CYCLES - 1));

  // Next phase: restart, advance with wrap, or hold.
  always_comb begin
    phase_nxt = phase_cnt;
    if (clr) begin
      phase_nxt = '0;
    end else if (adv) begin
      phase_nxt = wrap ? '0 : phase_cnt + PW'(1);
    end
  end

  // Phase register and registered line: low while phase is below the low length.
  always_ff @(posedge clkin) begin
    if (rst) begin
      phase_cnt <= '0;
      ir_out    <= 1'b1;
    end else begin
      phase_cnt <= phase_nxt;
      ir_out    <= en_nxt ? !(phase_nxt < low_len_nxt) : 1'b1;
    end
  end

endmodule

// File: rtl/ir_cmd_tx.sv
// IR command transmitter: sends each accepted drive command as FRAMES_PER_CMD
// frames of a periodic active-low pattern.
// Optional build macro: IR_CMD_REPEAT_EN -- keep re-sending the latched command
// until a new one is accepted at a frame end.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | line high, ready for a command
// ST_SEND | pattern running; ready only on the hand-off cycle of a frame
module ir_cmd_tx
  import ir_cmd_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES     = PERIOD_CYCLES_DEF,
  parameter int unsigned PERIODS_PER_FRAME = PERIODS_PER_FRAME_DEF,
  parameter int unsigned FRAMES_PER_CMD    = FRAMES_PER_CMD_DEF,
  parameter int unsigned LOW_UP            = LOW_UP_DEF,
  parameter int unsigned LOW_RIGHT         = LOW_RIGHT_DEF,
  parameter int unsigned LOW_LEFT          = LOW_LEFT_DEF
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_code,
  output logic       cmd_ready,
  output logic       ir_out,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned PW = cnt_w(PERIOD_CYCLES);
  localparam int unsigned FW = cnt_w(PERIODS_PER_FRAME);
  localparam int unsigned CW = cnt_w(FRAMES_PER_CMD);

  tx_state_e     state, state_nxt;
  cmd_code_e     code, code_nxt;
  logic [FW-1:0] period_cnt, period_cnt_nxt;
  logic [CW-1:0] frame_cnt, frame_cnt_nxt;
  logic [PW-1:0] low_len, low_len_nxt;
  logic          phase_wrap;
  logic          pwm_clr, pwm_adv, pwm_en_nxt;
  logic          period_last, frame_last, cmd_end, accept;

  function automatic logic [PW-1:0] low_of(input cmd_code_e c);
    case (c)
      CMD_UP:    low_of = PW'(LOW_UP);
      CMD_RIGHT: low_of = PW'(LOW_RIGHT);
      CMD_LEFT:  low_of = PW'(LOW_LEFT);
      default:   low_of = '0;
    endcase
  endfunction

  ir_pwm_period #(
    .PERIOD_CYCLES (PERIOD_CYCLES),
    .PW            (PW)
  ) u_pwm (
    .clkin       (clkin),
    .rst         (rst),
    .clr         (pwm_clr),
    .adv         (pwm_adv),
    .en_nxt      (pwm_en_nxt),
    .low_len_nxt (low_len_nxt),
    .wrap        (phase_wrap),
    .ir_out      (ir_out)
  );

  // State, latched command and frame/period counters.
  always_ff @(posedge clkin) begin
    if (rst) begin
      state      <= ST_IDLE;
      code       <= CMD_STOP;
      period_cnt <= '0;
      frame_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      code       <= code_nxt;
      period_cnt <= period_cnt_nxt;
      frame_cnt  <= frame_cnt_nxt;
    end
  end

  // Next-state, counter sequencing and handshake outputs.
  always_comb begin
    low_len     = low_of(code);
    period_last = (period_cnt == FW'(PERIODS_PER_FRAME - 1));
    frame_last  = (frame_cnt == CW'(FRAMES_PER_CMD - 1));
    busy        = (state == ST_SEND);
    frame_done  = busy && phase_wrap && period_last;
`ifdef IR_CMD_REPEAT_EN
    cmd_end     = frame_done;
`else
    cmd_end     = frame_done && frame_last;
`endif
    cmd_ready   = (state == ST_IDLE) || cmd_end;
    accept      = cmd_valid && cmd_ready;

    state_nxt      = state;
    code_nxt       = code;
    period_cnt_nxt = period_cnt;
    frame_cnt_nxt  = frame_cnt;
    pwm_clr        = 1'b0;
    pwm_adv        = 1'b0;
    pwm_en_nxt     = 1'b0;

    if (accept) begin
      // New command, possibly back-to-back on the last cycle of the previous one.
      state_nxt      = ST_SEND;
      code_nxt       = cmd_code_e'(cmd_code);
      period_cnt_nxt = '0;
      frame_cnt_nxt  = '0;
      pwm_clr        = 1'b1;
      pwm_en_nxt     = 1'b1;
    end else if (state == ST_SEND) begin
`ifndef IR_CMD_REPEAT_EN
      if (cmd_end) begin
        state_nxt      = ST_IDLE;
        period_cnt_nxt = '0;
        frame_cnt_nxt  = '0;
        pwm_clr        = 1'b1;
      end else
`endif
      begin
        // Counters wrap naturally, so repeat mode just keeps running.
        pwm_adv    = 1'b1;
        pwm_en_nxt = 1'b1;
        if (phase_wrap) begin
          if (period_last) begin
            period_cnt_nxt = '0;
            frame_cnt_nxt  = frame_last ? '0 : frame_cnt + CW'(1);
          end else begin
            period_cnt_nxt = period_cnt + FW'(1);
          end
        end
      end
    end else begin
      pwm_clr = 1'b1;
    end

    low_len_nxt = low_of(code_nxt);
  end

  // A low length at or above the sub-period would never let the line go high.
  a_low_len_legal: assert property (@(posedge clkin) disable iff (rst)
                                    (32'(low_len) < PERIOD_CYCLES));

endmodule

// File: tb/tb_ir_cmd_tx.sv
// Directed bench for ir_cmd_tx at scaled timing (10-cycle sub-period, 4 per frame, 2 frames).
module tb_ir_cmd_tx;

  localparam int P     = 10;
  localparam int N     = 4;
  localparam int F     = 2;
  localparam int FRAME = P * N;
  localparam int TX    = FRAME * F;

  logic       clkin     = 1'b0;
  logic       rst       = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_code  = 2'd0;
  logic       cmd_ready, ir_out, busy, frame_done;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] code;
    int         low;
    int         total;
    int         win;
  } vec_t;

  vec_t tbl [4];

  always #5 clkin = ~clkin;

  ir_cmd_tx #(
    .PERIOD_CYCLES     (P),
    .PERIODS_PER_FRAME (N),
    .FRAMES_PER_CMD    (F),
    .LOW_UP            (3),
    .LOW_RIGHT         (5),
    .LOW_LEFT          (7)
  ) dut (
    .clkin      (clkin),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .cmd_ready  (cmd_ready),
    .ir_out     (ir_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  function automatic logic [3:0] outs();
    return {ir_out, cmd_ready, busy, frame_done};
  endfunction

  task automatic chk(input string name, input int k, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got {ir,rdy,busy,fd}=%b expected %b", name, k, act, exp);
    end
  endtask

  task automatic chk_cnt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic idle_check(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clkin);
      chk(name, i, outs(), 4'b1100);
      @(posedge clkin); #1;
    end
  endtask

  // Offer a command in an idle cycle; scramble cmd_code afterwards to show it is ignored.
  task automatic issue(input logic [1:0] code);
    cmd_valid = 1'b1;
    cmd_code  = code;
    @(negedge clkin);
    chk("accept_ready", 0, outs(), 4'b1100);
    @(posedge clkin); #1;
    cmd_valid = 1'b0;
    cmd_code  = ~code;
  endtask

  // Check ncyc pattern cycles; optionally hold the next command valid from cycle ncyc-1.
  task automatic check_tx(input string name, input int low, input int ncyc, input bit rdy_each,
                          input int exp_total, input int exp_win,
                          input bit nxt_v, input logic [1:0] nxt_code);
    int   lows;
    int   win;
    logic e_ir, e_rdy, e_fd;
    lows = 0;
    win  = 0;
    for (int k = 1; k <= ncyc; k++) begin
      if (nxt_v && k == ncyc - 1) begin
        cmd_valid = 1'b1;
        cmd_code  = nxt_code;
      end
      @(negedge clkin);
      e_ir  = (((k - 1) % P) < low) ? 1'b0 : 1'b1;
      e_fd  = ((k % FRAME) == 0);
      e_rdy = rdy_each ? e_fd : (k == ncyc);
      chk(name, k, outs(), {e_ir, e_rdy, 1'b1, e_fd});
      if (ir_out === 1'b0) begin
        lows++;
        if (k >= 11 && k <= 50) win++;
      end
      @(posedge clkin); #1;
      if (k == ncyc) cmd_valid = 1'b0;
    end
    chk_cnt({name, "_low_total"}, lows, exp_total);
    if (ncyc >= 50) chk_cnt({name, "_low_window"}, win, exp_win);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{code: 2'd1, low: 3, total: 24, win: 12};
    tbl[1] = '{code: 2'd2, low: 5, total: 40, win: 20};
    tbl[2] = '{code: 2'd3, low: 7, total: 56, win: 28};
    tbl[3] = '{code: 2'd0, low: 0, total: 0,  win: 0};

    // Reset held for three edges, then idle with no command.
    for (int i = 0; i < 3; i++) begin
      @(posedge clkin); #1;
      @(negedge clkin);
      chk("reset", i, outs(), 4'b1100);
    end
    @(posedge clkin); #1;
    rst = 1'b0;
    idle_check("idle_after_reset", 5);

`ifndef IR_CMD_REPEAT_EN
    for (int i = 0; i < 4; i++) begin
      issue(tbl[i].code);
      check_tx($sformatf("tbl%0d", i), tbl[i].low, TX, 1'b0, tbl[i].total, tbl[i].win, 1'b0, 2'd0);
      idle_check($sformatf("tbl%0d_idle", i), 1);
    end

    // RIGHT with LEFT held valid from its second-to-last cycle: seamless hand-off.
    issue(2'd2);
    check_tx("right_b2b", 5, TX, 1'b0, 40, 20, 1'b1, 2'd3);
    check_tx("left_b2b", 7, TX, 1'b0, 56, 28, 1'b0, 2'd0);
    idle_check("b2b_idle", 2);

    // Reset mid-frame during LEFT while the line is low.
    issue(2'd3);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clkin);
      chk("left_pre_reset", k, outs(), {((((k - 1) % P) < 7) ? 1'b0 : 1'b1), 1'b0, 1'b1, 1'b0});
      if (k < 15) begin
        @(posedge clkin); #1;
      end
    end
    rst = 1'b1;
    @(posedge clkin); #1;
    rst = 1'b0;
    @(negedge clkin);
    chk("after_mid_reset", 0, outs(), 4'b1100);
    @(posedge clkin); #1;
    issue(2'd1);
    check_tx("up_restart", 3, TX, 1'b0, 24, 12, 1'b0, 2'd0);
    idle_check("final_idle", 2);
`else
    // Repeat build: RIGHT keeps going past one command, then UP takes over at a frame end.
    issue(2'd2);
    check_tx("right_rep", 5, 3 * FRAME, 1'b1, 60, 20, 1'b1, 2'd1);
    check_tx("up_rep", 3, TX, 1'b1, 24, 12, 1'b0, 2'd0);
    rst = 1'b1;
    @(posedge clkin); #1;
    rst = 1'b0;
    @(negedge clkin);
    chk("rep_reset", 0, outs(), 4'b1100);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ir_cmd_tx.md
Name: ir_cmd_tx

Overview:
- IR command transmitter. It is the sending end of the robot's IR drive link.
- It encodes a 2-bit drive command (stop/up/right/left) as an active-low IR line with a fixed low-time per decision window; the receiver classifies each window by how many cycles the line was low.
- The low-time is spread as a periodic pattern with period dividing the window, so any receiver window fully inside a transmission sees the exact same low count regardless of phase alignment.

Parameters:
- PERIOD_CYCLES, 1000: cycles per sub-period of the low pattern.
- PERIODS_PER_FRAME, 25000: sub-periods per frame; frame = 25,000,000 cycles = one receiver window at 50 MHz.
- LOW_UP, 232: low cycles per sub-period for UP; 5.8M per frame, receiver band 5.0M–6.5M.
- LOW_RIGHT, 264: low cycles per sub-period for RIGHT; 6.6M per frame, band 6.5M–6.7M.
- LOW_LEFT, 276: low cycles per sub-period for LEFT; 6.9M per frame, band ≥6.7M.
- FRAMES_PER_CMD, 2: frames sent per accepted command; 2 guarantees at least one fully covered receiver window.

Ports:
- clkin  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_code  in  2  0=STOP, 1=UP, 2=RIGHT, 3=LEFT.
- cmd_ready  out  1  block can accept a command this cycle.
- ir_out  out  1  IR line, active-low (low = IR on); registered.
- busy  out  1  transmission in progress.
- frame_done  out  1  one-cycle pulse on the last cycle of each frame.

Behaviour:
- Reset (rst=1 at a clkin edge): ir_out=1, cmd_ready=1, busy=0, frame_done=0, all counters 0, state IDLE. Reset mid-transmission aborts immediately; the next cycle is idle-high.
- States:
  - IDLE: ir_out=1, cmd_ready=1. On cmd_valid&cmd_ready at edge t: latch code, select low_len (STOP→0), clear counters, go to SEND.
  - SEND: busy=1. The first cycle of the pattern is cycle t+1, i.e. ir_out is driven from edge t+1.
    - ir_out=0 iff phase_cnt < low_len, else 1.
- Counters:
  - phase_cnt counts 0..PERIOD_CYCLES-1 and wraps; on wrap, period_cnt increments.
  - period_cnt counts 0..PERIODS_PER_FRAME-1; on wrap, frame_cnt increments and frame_done pulses.
- Per-frame low count is exactly low_len×PERIODS_PER_FRAME. STOP transmits all-high frames for the full duration (busy stays 1).
- Command acceptance:
  - cmd_ready=0 during SEND, except on the last cycle of the last frame, where cmd_ready=1.
  - If accepted there, the new command starts on the next cycle with phase_cnt=0: no idle gap, no duplicated cycle.
  - Otherwise go to IDLE.
- cmd_code is sampled only on handshake. Changes during SEND are ignored.
- Width rule: counters sized with $clog2 of their parameter; compare is unsigned. low_len ≥ PERIOD_CYCLES is illegal (assertion); legal range is 0..PERIOD_CYCLES-1.

Optional Feature:
- IR_CMD_REPEAT_EN defined: on completion with no new command, re-send the latched command indefinitely (busy=1; cmd_ready=1 on the last cycle of every frame). STOP repeats as all-high frames.
- Undefined: return to IDLE after FRAMES_PER_CMD frames.

Decomposition:
- Package ir_cmd_pkg:
  - cmd_code typedef/enum (CMD_STOP=0, CMD_UP=1, CMD_RIGHT=2, CMD_LEFT=3).
  - Default PERIOD_CYCLES, PERIODS_PER_FRAME and LOW_* constants.
  - Receiver band thresholds (5.0M/6.5M/6.7M), shared with the receiver side.
- Sub-module ir_pwm_period: phase counter plus compare against low_len, producing a wrap strobe. Frame/command sequencing stays in ir_cmd_tx.

Test Plan (scaled: PERIOD_CYCLES=10, PERIODS_PER_FRAME=4, FRAMES_PER_CMD=2, LOW_UP=3, LOW_RIGHT=5, LOW_LEFT=7):
- Reset held 3 cycles, then released with no command → ir_out=1, cmd_ready=1, busy=0 throughout.
- UP accepted at cycle t → ir_out low at t+1..t+3, high t+4..t+10, pattern repeats; 24 low cycles over 80; frame_done pulses at t+40 and t+80; idle-high from t+81.
- LEFT held valid from the last cycle of a RIGHT transmission → ready=1 on exactly that cycle; LEFT pattern (7 low) begins the next cycle with no gap; any 40-cycle window inside LEFT counts 28 low.
- STOP accepted → busy=1 for 80 cycles with ir_out=1 throughout; cmd_ready=0 until the last cycle.
- rst asserted mid-frame during LEFT while ir_out=0 → next cycle ir_out=1, busy=0, cmd_ready=1; a new UP restarts with phase 0.
- IR_CMD_REPEAT_EN defined, RIGHT accepted, no further commands → RIGHT pattern continues past 80 cycles, with frame_done every 40 cycles; a new UP at a frame end switches seamlessly.
